// File: rtl/vend_pkg.sv
// Shared definitions for the vending fare path: FSM states, verdict codes and saturation limits.
// Verdict codes are identical to the compare engine's 2-bit result codes.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESULT = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam logic [1:0] VERDICT_EXACT  = 2'b00;
    localparam logic [1:0] VERDICT_SHORT  = 2'b01;
    localparam logic [1:0] VERDICT_CHANGE = 2'b10;
    localparam logic [1:0] VERDICT_BAD    = 2'b11;

    localparam logic signed [7:0] SAT_MAX = 8'sd127;
    localparam logic signed [7:0] SAT_MIN = 8'sh80;

    // Engine results carry only a 2-bit code; anything else is corrupt.
    function automatic logic result_legal(input logic [7:0] r);
        return (r[7:2] == 6'd0) && (r[1:0] != VERDICT_BAD);
    endfunction

endpackage

// File: rtl/fare_check_if.sv
// Link between fare_check (master) and the signed compare engine (slave).
// Request is a one-cycle ready pulse plus held data; response is ready/data plus a done pulse.
interface fare_check_if;
    logic       cmp_RDY_out;
    logic [7:0] cmp_DATA_out;
    logic       cmp_RDY_in;
    logic [7:0] cmp_DATA_in;
    logic       cmp_done_in;

    modport master (
        output cmp_RDY_out,
        output cmp_DATA_out,
        input  cmp_RDY_in,
        input  cmp_DATA_in,
        input  cmp_done_in
    );

    modport slave (
        input  cmp_RDY_out,
        input  cmp_DATA_out,
        output cmp_RDY_in,
        output cmp_DATA_in,
        output cmp_done_in
    );
endinterface

// File: rtl/fare_check_sat_sub8.sv
// Combinational a - b on unsigned bytes, result saturated to signed 8 bits; zero latency, no handshake.
module sat_sub8
    import vend_pkg::*;
(
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic signed [7:0] y
);

    logic signed [8:0] diff;

    always_comb begin
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        if (diff > 9'sd127) begin
            y = SAT_MAX;
        end else if (diff < -9'sd128) begin
            y = SAT_MIN;
        end else begin
            y = diff[7:0];
        end
    end

endmodule

// File: rtl/fare_check.sv
// Fare check initiator: sends saturated (paid - price) to the compare engine and reports verdict/change.
// One request in flight; start is ignored while busy; a watchdog turns a silent engine into err.
module fare_check
    import vend_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  price,
    input  logic [7:0]  paid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  verdict,
    output logic [7:0]  change,
    output logic        err,
    fare_check_if.master cmp
);

    state_t            state, state_nxt;
    logic [7:0]        price_q, paid_q, result_q;
    logic [CNT_W-1:0]  wd;
    logic              wd_expire;
    logic signed [7:0] sat_diff;

    logic              busy_nxt, done_nxt, err_nxt, rdy_nxt;
    logic [1:0]        verdict_nxt;
    logic [7:0]        change_nxt, data_nxt;
    logic              rdy_q;
    logic [7:0]        data_q;

    sat_sub8 u_sat (
        .a (paid_q),
        .b (price_q),
        .y (sat_diff)
    );

    assign wd_expire        = (wd + CNT_W'(1)) == CNT_W'(TIMEOUT);
    assign cmp.cmp_RDY_out  = rdy_q;
    assign cmp.cmp_DATA_out = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A done pulse beats a watchdog expiry landing in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cmp.cmp_done_in) begin
                    state_nxt = ST_RESULT;
                end else if (wd_expire) begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_RESULT: state_nxt = ST_IDLE;
            ST_FAIL:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        verdict_nxt = verdict;
        change_nxt  = change;
        rdy_nxt     = 1'b0;
        data_nxt    = data_q;
        case (state)
            ST_IDLE: begin
                busy_nxt = start;
                data_nxt = 8'd0;
            end
            ST_LOAD: begin
                rdy_nxt  = 1'b1;
                data_nxt = sat_diff;
            end
            ST_WAIT: begin
                if (cmp.cmp_done_in || wd_expire) data_nxt = 8'd0;
            end
            ST_RESULT: begin
                if (result_legal(result_q)) begin
                    done_nxt    = 1'b1;
                    verdict_nxt = result_q[1:0];
                    change_nxt  = (result_q[1:0] == VERDICT_CHANGE) ? (paid_q - price_q) : 8'd0;
                end else begin
                    err_nxt     = 1'b1;
                    verdict_nxt = VERDICT_BAD;
                    change_nxt  = 8'd0;
                end
            end
            ST_FAIL: begin
                err_nxt     = 1'b1;
                verdict_nxt = VERDICT_BAD;
                change_nxt  = 8'd0;
                data_nxt    = 8'd0;
            end
            default: begin
                busy_nxt = 1'b0;
                data_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            verdict  <= 2'b00;
            change   <= 8'd0;
            rdy_q    <= 1'b0;
            data_q   <= 8'd0;
            price_q  <= 8'd0;
            paid_q   <= 8'd0;
            result_q <= 8'd0;
            wd       <= '0;
        end else begin
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            verdict <= verdict_nxt;
            change  <= change_nxt;
            rdy_q   <= rdy_nxt;
            data_q  <= data_nxt;

            if (state == ST_IDLE && start) begin
                price_q <= price;
                paid_q  <= paid;
            end

            if (state == ST_LOAD) begin
                wd <= '0;
            end else if (state == ST_WAIT) begin
                wd <= wd + CNT_W'(1);
            end

            // Engine ready is held two cycles; the later capture carries the valid code.
            if (state_nxt == ST_IDLE) begin
                result_q <= 8'd0;
            end else if (state == ST_WAIT && cmp.cmp_RDY_in) begin
                result_q <= cmp.cmp_DATA_in;
            end
        end
    end

endmodule

// File: tb/tb_fare_check.sv
// Scoreboard bench for fare_check with a behavioural compare engine and stub modes.
module tb_fare_check;

    localparam int M_REAL    = 0;
    localparam int M_SILENT  = 1;
    localparam int M_ILLEGAL = 2;
    localparam int M_DOUBLE  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] price, paid;
    logic       busy, done, err;
    logic [1:0] verdict;
    logic [7:0] change;

    fare_check_if cmp_if();

    fare_check #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .price   (price),
        .paid    (paid),
        .busy    (busy),
        .done    (done),
        .verdict (verdict),
        .change  (change),
        .err     (err),
        .cmp     (cmp_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [1:0] verdict;
        logic [7:0] change;
        logic [7:0] cmp_data;
        int         lat;
        int         t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   resp_cnt = 0;
    int   eng_mode = M_REAL;
    int   eng_t = -1;
    int   stray_req = 0;
    int   stray_ack = 0;
    logic [7:0] eng_seen;
    bit   rdy_prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Compare engine: reacts to the ready pulse, answers with the sign of the difference.
    always @(negedge clk) begin
        cmp_if.cmp_RDY_in  = 1'b0;
        cmp_if.cmp_done_in = 1'b0;
        cmp_if.cmp_DATA_in = 8'd0;
        if (rst) begin
            eng_t = -1;
        end else if (eng_t < 0) begin
            if (stray_req != stray_ack) begin
                stray_ack          = stray_req;
                cmp_if.cmp_RDY_in  = 1'b1;
                cmp_if.cmp_done_in = 1'b1;
                cmp_if.cmp_DATA_in = 8'h02;
            end else if (cmp_if.cmp_RDY_out) begin
                eng_t = 0;
            end
        end else begin
            eng_t++;
            case (eng_t)
                1: begin
                    eng_seen           = cmp_if.cmp_DATA_out;
                    cmp_if.cmp_RDY_in  = 1'b1;
                    cmp_if.cmp_DATA_in = (eng_mode == M_DOUBLE) ? 8'h02 : 8'($urandom);
                end
                2: begin
                    cmp_if.cmp_RDY_in = 1'b1;
                    if (eng_mode == M_ILLEGAL)     cmp_if.cmp_DATA_in = 8'h03;
                    else if (eng_mode == M_DOUBLE) cmp_if.cmp_DATA_in = 8'h01;
                    else if (eng_seen == 8'd0)     cmp_if.cmp_DATA_in = 8'h00;
                    else if (eng_seen[7])          cmp_if.cmp_DATA_in = 8'h01;
                    else                           cmp_if.cmp_DATA_in = 8'h02;
                end
                5: if (eng_mode != M_SILENT) cmp_if.cmp_done_in = 1'b1;
                6: eng_t = -1;
                default: ;
            endcase
        end
    end

    // Monitor: checks the request pulse and every done/err response against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rdy_prev = 1'b0;
        end else begin
            if (rdy_prev) chk("rdy_width", cmp_if.cmp_RDY_out, 0);
            if (cmp_if.cmp_RDY_out && exp_q.size() > 0)
                chk("cmp_data", cmp_if.cmp_DATA_out, exp_q[0].cmp_data);
            rdy_prev = cmp_if.cmp_RDY_out;
            if (done || err) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {30'b0, done, err}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done",      done, !mon_e.is_err);
                    chk("err",       err, mon_e.is_err);
                    chk("verdict",   verdict, mon_e.verdict);
                    chk("change",    change, mon_e.change);
                    chk("latency",   cyc - mon_e.t0, mon_e.lat);
                    chk("busy_resp", busy, 1);
                    chk("data_idle", cmp_if.cmp_DATA_out, 0);
                end
            end
        end
    end

    task automatic launch(input logic [7:0] pr, input logic [7:0] pd, input int mode);
        exp_t e;
        int   d;
        @(negedge clk);
        eng_mode = mode;
        start    = 1'b1;
        price    = pr;
        paid     = pd;
        d = int'(pd) - int'(pr);
        if (d > 127)  d = 127;
        if (d < -128) d = -128;
        e.cmp_data = 8'(d);
        e.t0       = cyc;
        e.lat      = 9;
        e.is_err   = 1'b0;
        e.change   = 8'd0;
        case (mode)
            M_SILENT:  begin e.is_err = 1'b1; e.verdict = 2'b11; e.lat = 19; end
            M_ILLEGAL: begin e.is_err = 1'b1; e.verdict = 2'b11; end
            M_DOUBLE:  e.verdict = 2'b01;
            default: begin
                if (pd == pr)     e.verdict = 2'b00;
                else if (pd < pr) e.verdict = 2'b01;
                else begin
                    e.verdict = 2'b10;
                    e.change  = pd - pr;
                end
            end
        endcase
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        price = 8'($urandom);
        paid  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            chk("wait_budget", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        chk("busy_drop", busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_done"},    done, 0);
        chk({tag, "_err"},     err, 0);
        chk({tag, "_verdict"}, verdict, 0);
        chk({tag, "_change"},  change, 0);
        chk({tag, "_rdy"},     cmp_if.cmp_RDY_out, 0);
        chk({tag, "_data"},    cmp_if.cmp_DATA_out, 0);
    endtask

    initial begin
        int r0;
        logic [7:0] pr, pd;
        rst   = 1'b1;
        start = 1'b0;
        price = 8'd0;
        paid  = 8'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        launch(8'd50, 8'd50, M_REAL);   wait_idle();
        launch(8'd30, 8'd200, M_REAL);  wait_idle();
        launch(8'd200, 8'd10, M_REAL);  wait_idle();
        launch(8'd0, 8'd255, M_REAL);   wait_idle();
        launch(8'd255, 8'd0, M_REAL);   wait_idle();

        // Silent engine, then a new start in the err cycle itself.
        launch(8'd10, 8'd20, M_SILENT);
        repeat (17) @(negedge clk);
        launch(8'd20, 8'd20, M_REAL);
        wait_idle();

        launch(8'd5, 8'd9, M_ILLEGAL);    wait_idle();
        launch(8'd100, 8'd50, M_DOUBLE);  wait_idle();

        // Start while busy must not disturb the latched operands.
        launch(8'd40, 8'd60, M_REAL);
        @(negedge clk);
        start = 1'b1; price = 8'd1; paid = 8'd250;
        @(negedge clk);
        start = 1'b0;
        chk("busy_hold", busy, 1);
        wait_idle();

        // Stray engine response in IDLE.
        r0 = resp_cnt;
        stray_req++;
        repeat (5) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_resp", resp_cnt - r0, 0);
        launch(8'd77, 8'd99, M_REAL);  wait_idle();

        // Reset in the middle of WAIT.
        launch(8'd70, 8'd90, M_REAL);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_wait");
        r0 = resp_cnt;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("no_resp_after_rst", resp_cnt - r0, 0);

        for (int i = 0; i < 40; i++) begin
            pr = 8'($urandom);
            pd = ($urandom_range(0, 3) == 0) ? pr : 8'($urandom);
            launch(pr, pd, M_REAL);
            wait_idle();
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
